pc_redirect_unit: RTL

Program-counter register and next-PC selector that sits directly downstream of `branch_module`, consuming its BEQ/BNE decisions. It drives the fetch address to instruction memory through a valid/ready handshake, redirects to the branch target on a taken branch, and flushes the wrong-path instruction. It also halts on a misaligned target and counts taken branches.

---
 rtl/rv_core_pkg.sv | 19 +
 rtl/branch_target_calc.sv | 21 ++
 rtl/pc_redirect_unit.sv | 108 ++++++++++
 3 files changed

// File: rtl/rv_core_pkg.sv
// Shared core definitions.
//   state_e    : fetch-side FSM states used by pc_redirect_unit
//   INSN_BYTES : size of one instruction, used for the sequential PC step
//   F3_BEQ/BNE : funct3 encodings of the conditional branches
package rv_core_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH    = 2'd1,
    REDIRECT = 2'd2,
    HALT     = 2'd3
  } state_e;

  localparam int unsigned INSN_BYTES = 4;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

endpackage

// File: rtl/branch_target_calc.sv
// Branch target adder.
// Ports:
//   br_pc_i    : PC of the resolving branch
//   imm_i      : sign-extended B-type immediate in halfword units
//   target_o   : br_pc_i + (imm_i << 1), wrapping modulo 2^WIDTH
//   misalign_o : target is not word aligned (bit 1 set)
module branch_target_calc #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] br_pc_i,
  input  logic [WIDTH-1:0] imm_i,
  output logic [WIDTH-1:0] target_o,
  output logic             misalign_o
);

  // The shift drops the immediate's top bit; the sum simply wraps.
  assign target_o   = br_pc_i + {imm_i[WIDTH-2:0], 1'b0};
  // Bit 0 is always clear, so only bit 1 can break word alignment.
  assign misalign_o = target_o[1];

endmodule

// File: rtl/pc_redirect_unit.sv
// PC register and next-PC selection for the fetch stage.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   BRANCH         : a branch resolves this cycle (qualifies BEQ/BNE)
//   BEQ, BNE       : taken decisions from branch_module
//   BR_PC, IMM     : branch PC and halfword immediate for the target
//   STALL          : hold the PC
//   IF_READY       : instruction memory accepts PC_OUT this cycle
//   IF_VALID       : PC_OUT is a valid fetch request
//   PC_OUT         : current fetch address
//   FLUSH          : squash the wrong-path instruction in IF/ID
//   MISALIGN       : misaligned branch target seen, unit halted
//   BR_TAKEN_CNT   : saturating count of honoured taken branches
// All outputs come straight from registers.
module pc_redirect_unit
  import rv_core_pkg::*;
#(
  parameter int               WIDTH    = 64,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int               CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             BRANCH,
  input  logic             BEQ,
  input  logic             BNE,
  input  logic [WIDTH-1:0] BR_PC,
  input  logic [WIDTH-1:0] IMM,
  input  logic             STALL,
  input  logic             IF_READY,
  output logic             IF_VALID,
  output logic [WIDTH-1:0] PC_OUT,
  output logic             FLUSH,
  output logic             MISALIGN,
  output logic [CNT_W-1:0] BR_TAKEN_CNT
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             if_valid_q, flush_q, misalign_q;

  logic [WIDTH-1:0] target;
  logic             tgt_misalign;
  logic             taken;

  branch_target_calc #(.WIDTH(WIDTH)) u_btc (
    .br_pc_i   (BR_PC),
    .imm_i     (IMM),
    .target_o  (target),
    .misalign_o(tgt_misalign)
  );

  // BEQ/BNE are undefined unless BRANCH is high, so BRANCH gates them first.
  assign taken = BRANCH & (BEQ | BNE);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        // A taken branch wins over both STALL and a stalled handshake.
        if (taken) begin
          if (tgt_misalign) begin
            state_d = HALT;
          end else begin
            state_d = REDIRECT;
            pc_d    = target;
            if (!(&cnt_q)) cnt_d = cnt_q + 1'b1;
          end
        end else if (IF_READY && !STALL) begin
          pc_d = pc_q + WIDTH'(INSN_BYTES);
        end
      end
      REDIRECT: state_d = FETCH;
      HALT:     state_d = HALT;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      cnt_q      <= '0;
      if_valid_q <= 1'b0;
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      // Output flags are registered alongside the state they describe.
      if_valid_q <= (state_d == FETCH);
      flush_q    <= (state_d == REDIRECT);
      misalign_q <= (state_d == HALT);
    end
  end

  assign IF_VALID     = if_valid_q;
  assign PC_OUT       = pc_q;
  assign FLUSH        = flush_q;
  assign MISALIGN     = misalign_q;
  assign BR_TAKEN_CNT = cnt_q;

endmodule
